// File: rtl/img_rsz_raster_reorder.sv
// rtl/img_rsz_raster_reorder.sv - raster-order reorder buffer behind the image resizer
//
// Purpose: pixels arrive tagged with their (X,Y) location in arbitrary block-completion
// order. Each is written into an RSZ_W x RSZ_H frame store and an occupancy bit is set.
// A raster read pointer drains occupied locations in strict raster order into one output
// register, tagging each pixel with SOF/EOL/EOF.
//
// Ports:
//   Clk, Reset              clock, asynchronous active-high reset
//   InPxlData/X/Y/Vld/Rdy   input pixel stream (ready only drops during Abort)
//   Abort                   synchronous clear of occupancy, pointers and output
//   OutPxlData/Sof/Eol/Eof  raster-ordered output pixel and frame markers
//   OutVld/OutRdy           output handshake
//   FrameCnt                number of EOF handshakes, wraps
//   ErrDup, ErrRange        sticky error flags, cleared only by Reset
//
// Build option: define IMG_RSZ_REORDER_ERR_EN to enable ErrDup/ErrRange; otherwise both
// are tied low (duplicates still overwrite, out-of-range pixels are still dropped).

module img_rsz_raster_reorder #(
  parameter  int PRIM_W    = 8,
  parameter  int COLOR_NUM = 3,
  parameter  int RSZ_W     = 8,
  parameter  int RSZ_H     = 8,
  localparam int X_W       = $clog2(RSZ_W),
  localparam int Y_W       = $clog2(RSZ_H)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [COLOR_NUM*PRIM_W-1:0] InPxlData,
  input  logic [X_W-1:0]              InPxlX,
  input  logic [Y_W-1:0]              InPxlY,
  input  logic                        InPxlVld,
  output logic                        InPxlRdy,
  input  logic                        Abort,
  output logic [COLOR_NUM*PRIM_W-1:0] OutPxlData,
  output logic                        OutSof,
  output logic                        OutEol,
  output logic                        OutEof,
  output logic                        OutVld,
  input  logic                        OutRdy,
  output logic [15:0]                 FrameCnt,
  output logic                        ErrDup,
  output logic                        ErrRange
);

  localparam int DW = COLOR_NUM * PRIM_W;
  localparam int N  = RSZ_W * RSZ_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(RSZ_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(RSZ_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [N];
  logic [N-1:0]    occ_q, occ_d;
  logic [X_W-1:0]  rd_x_q, rd_x_d;
  logic [Y_W-1:0]  rd_y_q, rd_y_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_vld_q, out_vld_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eol_q, out_eol_d;
  logic            out_eof_q, out_eof_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            in_range, wr_en, rd_en, out_hs;
  logic [IW-1:0]   wr_idx, rd_idx;

  assign InPxlRdy = !Abort;
  // Widen before comparing so the check stays meaningful for non-power-of-two sizes.
  assign in_range = (int'(InPxlX) < RSZ_W) && (int'(InPxlY) < RSZ_H);
  assign wr_en    = InPxlVld && InPxlRdy && in_range;
  assign wr_idx   = IW'(InPxlY) * IW'(RSZ_W) + IW'(InPxlX);
  assign rd_idx   = IW'(rd_y_q) * IW'(RSZ_W) + IW'(rd_x_q);
  assign out_hs   = out_vld_q && OutRdy;
  assign rd_en    = !Abort && occ_q[rd_idx] && (!out_vld_q || OutRdy);

  always_comb begin
    occ_d       = occ_q;
    rd_x_d      = rd_x_q;
    rd_y_d      = rd_y_q;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    frame_cnt_d = frame_cnt_q + 16'(out_hs && out_eof_q);
    state_d     = state_q;

    if (out_hs) out_vld_d = 1'b0;

    if (rd_en) begin
      occ_d[rd_idx] = 1'b0;
      out_vld_d     = 1'b1;
      out_data_d    = mem_q[rd_idx];
      out_sof_d     = (rd_x_q == '0) && (rd_y_q == '0);
      out_eol_d     = (rd_x_q == X_LAST);
      out_eof_d     = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);
      if (rd_x_q == X_LAST) begin
        rd_x_d = '0;
        rd_y_d = (rd_y_q == Y_LAST) ? '0 : rd_y_q + 1'b1;
      end else begin
        rd_x_d = rd_x_q + 1'b1;
      end
    end

    // Applied after the read clear: a same-cycle write to the location being read is
    // the next frame's pixel and must stay occupied.
    if (wr_en) occ_d[wr_idx] = 1'b1;

    if (Abort) begin
      occ_d     = '0;
      rd_x_d    = '0;
      rd_y_d    = '0;
      out_vld_d = 1'b0;
    end

    // The FSM only tracks whether a frame is in flight; it gates nothing.
    case (state_q)
      IDLE:    if (wr_en) state_d = ACTIVE;
      ACTIVE:  if (out_hs && out_eof_q && (occ_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort) state_d = IDLE;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame store has no reset; occupancy alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_idx] <= InPxlData;
  end

`ifdef IMG_RSZ_REORDER_ERR_EN
  logic err_dup_q, err_range_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      // An occupied location being drained this cycle is a legal next-frame write.
      if (wr_en && occ_q[wr_idx] && !(rd_en && (rd_idx == wr_idx))) err_dup_q <= 1'b1;
      if (InPxlVld && InPxlRdy && !in_range) err_range_q <= 1'b1;
    end
  end

  assign ErrDup   = err_dup_q;
  assign ErrRange = err_range_q;
`else
  assign ErrDup   = 1'b0;
  assign ErrRange = 1'b0;
`endif

  assign OutPxlData = out_data_q;
  assign OutVld     = out_vld_q;
  assign OutSof     = out_sof_q;
  assign OutEol     = out_eol_q;
  assign OutEof     = out_eof_q;
  assign FrameCnt   = frame_cnt_q;

endmodule
